uart_rx_fifo: RTL

//  Downstream consumer of uart_receiver. Synchronises the receiver's Rx_VALID/Rx_FERROR/Rx_PERROR levels

---
 rtl/uart_rx_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronises uart_receiver status levels into clk and queues
// each received byte in a DEPTH-entry first-word-fall-through FIFO.
// Ports: clk, reset (async, active low), rx_data/rx_valid/rx_ferror/rx_perror
// from the receiver, rd_en/clr_ovf from the host; rd_data, empty, full,
// level, overflow to the host.
// Optional macro UART_RX_FIFO_ERRCNT_EN adds clr_cnt, ferr_cnt, perr_cnt
// (saturating error-edge counters).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferror,
  input  logic                  rx_perror,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`ifdef UART_RX_FIFO_ERRCNT_EN
  ,
  input  logic                  clr_cnt,
  output logic [7:0]            ferr_cnt,
  output logic [7:0]            perr_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  // bit 0: valid, bit 1: ferror, bit 2: perror
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] rise;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic push;
  logic pop;
  logic do_push;
  logic drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      rise  <= '0;
    end else begin
      sync1 <= {rx_perror, rx_ferror, rx_valid};
      sync2 <= sync1;
      prev  <= sync2;
      // registered strobe: byte is written on the 4th edge after rise
      rise  <= sync2 & ~prev;
    end
  end

  assign push    = rise[0];
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign pop     = rd_en & ~empty;
  // when full, a simultaneous pop frees the slot being written
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !do_push) begin
        level <= level - LVL_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ferr_cnt <= '0;
      perr_cnt <= '0;
    end else if (clr_cnt) begin
      ferr_cnt <= '0;
      perr_cnt <= '0;
    end else begin
      if (rise[1] && ferr_cnt != 8'hFF) begin
        ferr_cnt <= ferr_cnt + 8'd1;
      end
      if (rise[2] && perr_cnt != 8'hFF) begin
        perr_cnt <= perr_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_err;
  assign unused_err = rise[1] ^ rise[2];
`endif

endmodule
